// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - four-digit seven-segment scan controller with timed message overlay
//
// Purpose: multiplexes a 4-digit active-low seven-segment display. A free-running
// slot counter steps the active digit 3,2,1,0; every digit slot starts with a
// short blanked window. All four digit bytes come from one frame register that
// is only reloaded on the frame boundary, so a frame never tears mid-scan.
// A requester can overlay a message pattern for HOLD_CYCLES cycles.
//
// Ports:
//   clk      - clock, everything on its rising edge
//   rst      - synchronous active-high reset
//   idleSeg  - default pattern, [31:24] leftmost digit, gfedcba+dp, active-low
//   msgSeg   - message pattern, same format, valid while msgReq is high
//   msgReq   - level-held message request
//   msgAck   - one-cycle pulse when a request is accepted
//   busy     - high while a message is being shown
//   an       - digit anodes, active-low, an[3] leftmost
//   seg      - segment drive for the active digit, active-low

module disp_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int HOLD_CYCLES  = 200000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] idleSeg,
    input  logic [31:0] msgSeg,
    input  logic        msgReq,
    output logic        msgAck,
    output logic        busy,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MSG  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        dig_q, dig_d;
    logic [31:0]       frm_q, frm_d;
    logic [31:0]       latch_q, latch_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ack_q, ack_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic              slot_end;
    logic              frame_end;
    logic [7:0]        sel_byte;

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        dig_d    = dig_q;
        frm_d    = frm_q;
        state_d  = state_q;
        hold_d   = hold_q;
        latch_d  = latch_q;
        ack_d    = 1'b0;
        an_d     = 4'b1111;
        seg_d    = 8'hFF;
        sel_byte = 8'hFF;

        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (dig_q == 2'd0);

        // Scan timing runs regardless of the message FSM.
        if (slot_end) begin
            cnt_d = '0;
            dig_d = dig_q - 2'd1;
        end

        // Frame source follows the current state, so a message that ends on
        // this very cycle still owns the frame being loaded now.
        if (frame_end) begin
            frm_d = (state_q == S_MSG) ? latch_q : idleSeg;
        end

        case (state_q)
            S_IDLE: begin
                if (msgReq) begin
                    latch_d = msgSeg;
                    ack_d   = 1'b1;
                    hold_d  = '0;
                    state_d = S_MSG;
                end
            end
            S_MSG: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (dig_q)
            2'd3:    sel_byte = frm_q[31:24];
            2'd2:    sel_byte = frm_q[23:16];
            2'd1:    sel_byte = frm_q[15:8];
            default: sel_byte = frm_q[7:0];
        endcase

        if (cnt_q >= BLANK_END) begin
            an_d  = ~(4'b0001 << dig_q);
            seg_d = sel_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dig_q   <= 2'd3;
            frm_q   <= 32'hFFFF_FFFF;
            latch_q <= 32'hFFFF_FFFF;
            hold_q  <= '0;
            ack_q   <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            frm_q   <= frm_d;
            latch_q <= latch_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign msgAck = ack_q;
    assign busy   = (state_q == S_MSG);
    assign an     = an_q;
    assign seg    = seg_q;

endmodule
